seq_tx: RTL and testbench



---
 rtl/seq_tx.sv | 133 +++++++++++++
 tb/tb_seq_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB first, one bit per
// clock, repeated a programmable number of times with a start/busy/done handshake.
module seq_tx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       st
);

   localparam int BC_W = $clog2(WIDTH);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] hold, hold_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [BC_W-1:0]  bitcnt, bitcnt_nxt;
   logic [CNT_W-1:0] repcnt, repcnt_nxt;
   logic             x_nxt, valid_nxt, busy_nxt, done_nxt;

   // State and datapath registers; outputs are registered from next-cycle values
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         hold   <= '0;
         shreg  <= '0;
         bitcnt <= '0;
         repcnt <= '0;
         x      <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         hold   <= hold_nxt;
         shreg  <= shreg_nxt;
         bitcnt <= bitcnt_nxt;
         repcnt <= repcnt_nxt;
         x      <= x_nxt;
         valid  <= valid_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

   assign st = state;

   always_comb begin
      state_nxt  = state;
      hold_nxt   = hold;
      shreg_nxt  = shreg;
      bitcnt_nxt = bitcnt;
      repcnt_nxt = repcnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (reps != '0) begin
                  hold_nxt   = pattern;
                  shreg_nxt  = pattern;
                  repcnt_nxt = reps;
                  state_nxt  = LOAD;
               end else begin
                  state_nxt  = DONE;
               end
            end
         end
         LOAD: begin
            bitcnt_nxt = BC_LAST;
            state_nxt  = SHIFT;
         end
         SHIFT: begin
            if (bitcnt == '0) begin
               // Reload straight from the hold copy so repetitions run gap-free
               if (repcnt > CNT_W'(1)) begin
                  repcnt_nxt = repcnt - CNT_W'(1);
                  shreg_nxt  = hold;
                  bitcnt_nxt = BC_LAST;
               end else begin
                  state_nxt  = DONE;
               end
            end else begin
               shreg_nxt  = shreg << 1;
               bitcnt_nxt = bitcnt - BC_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      x_nxt     = 1'b0;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      unique case (state_nxt)
         LOAD: begin
            busy_nxt = 1'b1;
         end
         SHIFT: begin
            x_nxt     = shreg_nxt[WIDTH-1];
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
         end
         DONE: begin
            done_nxt = 1'b1;
         end
         default: begin
            x_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: a job-level queue model predicts every output cycle, plus
// directed scenarios with hand-computed bit streams, counts and latencies.
module tb_seq_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] reps;
   logic       x, valid, busy, done;
   logic [1:0] st;

   seq_tx #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .pattern(pattern), .reps(reps),
      .x(x), .valid(valid), .busy(busy), .done(done), .st(st)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       x;
      logic       valid;
      logic       busy;
      logic       done;
      logic [1:0] st;
   } obs_t;

   localparam obs_t O_IDLE = '{x: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, st: 2'b00};
   localparam obs_t O_LOAD = '{x: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0, st: 2'b01};
   localparam obs_t O_DONE = '{x: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b1, st: 2'b11};

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   bit   model_on = 1'b0;
   obs_t exp_o = O_IDLE;
   obs_t mq[$];

   int   valid_cycs[$];
   int   done_cycs[$];
   logic rxq[$];
   int   n_busy = 0;
   int   n_st[4] = '{0, 0, 0, 0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
   endtask

   function automatic logic [31:0] vbits(input int s, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++)
         if (s + i < rxq.size()) v = {v[30:0], rxq[s + i]};
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Job-level model: an accepted start expands into the whole list of output cycles
   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         exp_o = O_IDLE;
         model_on = 1'b1;
      end else if (mq.size() != 0) begin
         exp_o = mq.pop_front();
      end else if (start) begin
         if (reps != 0) begin
            mq.push_back(O_LOAD);
            for (int r = 0; r < int'(reps); r++)
               for (int i = 7; i >= 0; i--)
                  mq.push_back('{x: pattern[i], valid: 1'b1, busy: 1'b1, done: 1'b0, st: 2'b10});
         end
         mq.push_back(O_DONE);
         mq.push_back(O_IDLE);
         exp_o = mq.pop_front();
      end else begin
         exp_o = O_IDLE;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("cycle_outputs", 32'({x, valid, busy, done, st}), 32'(exp_o));
         if (valid) begin
            valid_cycs.push_back(cyc);
            rxq.push_back(x);
         end
         if (busy) n_busy++;
         if (done) done_cycs.push_back(cyc);
         n_st[st]++;
      end
   end

   int v0, d0, b0, r0, s2, s3, k;

   task automatic snap();
      v0 = valid_cycs.size();
      d0 = done_cycs.size();
      b0 = n_busy;
      r0 = rxq.size();
      s2 = n_st[2];
      s3 = n_st[3];
   endtask

   task automatic start_job(input logic [7:0] p, input logic [3:0] r, output int kk);
      pattern = p;
      reps    = r;
      start   = 1'b1;
      @(negedge clk);
      kk    = cyc;
      start = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      pattern = '0;
      reps    = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({x, valid, busy, done, st}), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single pattern A6, one repetition
      snap();
      start_job(8'hA6, 4'd1, k);
      repeat (12) @(negedge clk);
      chk("t1_bits", vbits(r0, 8), 32'hA6);
      chk("t1_nvalid", valid_cycs.size() - v0, 8);
      chk("t1_first_lat", (valid_cycs.size() > v0) ? valid_cycs[v0] - k : -1, 1);
      chk("t1_done_lat", (done_cycs.size() > d0) ? done_cycs[d0] - k : -1, 9);
      chk("t1_ndone", done_cycs.size() - d0, 1);
      chk("t1_st_shift", n_st[2] - s2, 8);
      chk("t1_busy", n_busy - b0, 9);

      // A5 repeated three times, contiguous
      snap();
      start_job(8'hA5, 4'd3, k);
      repeat (30) @(negedge clk);
      chk("t2_bits", vbits(r0, 24), 32'hA5A5A5);
      chk("t2_nvalid", valid_cycs.size() - v0, 24);
      chk("t2_contig", (valid_cycs.size() >= v0 + 24) ? valid_cycs[v0 + 23] - valid_cycs[v0] : -1, 23);
      chk("t2_busy", n_busy - b0, 25);
      chk("t2_ndone", done_cycs.size() - d0, 1);

      // reps = 0 goes straight to DONE
      snap();
      start_job(8'hFF, 4'd0, k);
      repeat (4) @(negedge clk);
      chk("t3_nvalid", valid_cycs.size() - v0, 0);
      chk("t3_busy", n_busy - b0, 0);
      chk("t3_ndone", done_cycs.size() - d0, 1);
      chk("t3_done_lat", (done_cycs.size() > d0) ? done_cycs[d0] - k : -1, 0);
      chk("t3_st_done", n_st[3] - s3, 1);

      // start held and pattern changed during a 0F job
      snap();
      pattern = 8'h0F;
      reps    = 4'd1;
      start   = 1'b1;
      @(negedge clk);
      k = cyc;
      repeat (3) @(negedge clk);
      pattern = 8'hFF;
      repeat (8) @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk("t4_bits", vbits(r0, 16), 32'h0FFF);
      chk("t4_nvalid", valid_cycs.size() - v0, 16);
      chk("t4_second_lat", (valid_cycs.size() > v0 + 8) ? valid_cycs[v0 + 8] - k : -1, 12);
      chk("t4_ndone", done_cycs.size() - d0, 2);

      // Reset in the middle of a C3 x2 job
      snap();
      start_job(8'hC3, 4'd2, k);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_after_reset", 32'({x, valid, busy, done, st}), 32'd0);
      chk("t5_partial_n", rxq.size() - r0, 4);
      chk("t5_partial_bits", vbits(r0, 4), 32'hC);
      repeat (25) @(negedge clk);
      chk("t5_no_done", done_cycs.size() - d0, 0);
      snap();
      start_job(8'hC3, 4'd1, k);
      repeat (12) @(negedge clk);
      chk("t5_restart_bits", vbits(r0, 8), 32'hC3);
      chk("t5_restart_ndone", done_cycs.size() - d0, 1);

      // Back-to-back jobs 81 then 7E at minimum spacing
      snap();
      pattern = 8'h81;
      reps    = 4'd1;
      start   = 1'b1;
      @(negedge clk);
      k     = cyc;
      start = 1'b0;
      repeat (10) @(negedge clk);
      pattern = 8'h7E;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("t6_bits", vbits(r0, 16), 32'h817E);
      chk("t6_nvalid", valid_cycs.size() - v0, 16);
      chk("t6_gap", (valid_cycs.size() >= v0 + 9) ? valid_cycs[v0 + 8] - valid_cycs[v0 + 7] - 1 : -1, 3);
      chk("t6_ndone", done_cycs.size() - d0, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
